// File: rtl/instruction_fetch_stage.sv
// IF stage of the five-stage MIPS pipeline: PC, single-outstanding instruction
// fetch over req/gnt/rvalid, and the IF/ID output register with a one-word skid.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nx;
    logic [31:0] r_pending_pc;
    logic [31:0] w_pending_pc_nx;
    logic        r_drop;
    logic        w_drop_nx;
    logic        r_skid_valid;
    logic        w_skid_valid_nx;
    logic [31:0] r_skid_instr;
    logic [31:0] w_skid_instr_nx;
    logic [31:0] r_skid_pc;
    logic [31:0] w_skid_pc_nx;
    logic        r_valid;
    logic        w_valid_nx;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nx;
    logic [31:0] r_out_pc;
    logic [31:0] w_out_pc_nx;
    logic [31:0] r_out_pc4;
    logic [31:0] w_out_pc4_nx;
    logic        r_req;
    logic        w_req_nx;
    logic        w_slot_free;
    logic [31:0] w_redirect_pc;

    assign w_slot_free   = ~r_valid | ~i_stall;
    assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};

    // Next-state, PC and IF/ID register update; redirect overrides everything.
    always_comb begin
        w_state_nx      = r_state;
        w_pc_nx         = r_pc;
        w_pending_pc_nx = r_pending_pc;
        w_drop_nx       = r_drop;
        w_skid_valid_nx = r_skid_valid;
        w_skid_instr_nx = r_skid_instr;
        w_skid_pc_nx    = r_skid_pc;
        // A word survives only while the ID stage is stalled on it.
        w_valid_nx      = r_valid & i_stall;
        w_instr_nx      = r_instr;
        w_out_pc_nx     = r_out_pc;
        w_out_pc4_nx    = r_out_pc4;

        if (i_redirect) begin
            w_pc_nx         = w_redirect_pc;
            w_valid_nx      = 1'b0;
            w_skid_valid_nx = 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        w_state_nx = S_REQ;
                        w_drop_nx  = 1'b0;
                    end else begin
                        w_state_nx = S_WAIT;
                        w_drop_nx  = 1'b1;
                    end
                end
                S_REQ: begin
                    if (i_imem_gnt) begin
                        w_state_nx = S_WAIT;
                        w_drop_nx  = 1'b1;
                    end else begin
                        w_state_nx = S_REQ;
                    end
                end
                default: begin
                    w_state_nx = S_REQ;
                end
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nx = S_REQ;
                end
                S_REQ: begin
                    if (i_imem_gnt) begin
                        w_pending_pc_nx = r_pc;
                        w_pc_nx         = r_pc + 32'd4;
                        w_state_nx      = S_WAIT;
                    end else begin
                        w_state_nx = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (!i_imem_rvalid) begin
                        w_state_nx = S_WAIT;
                    end else if (r_drop) begin
                        w_drop_nx  = 1'b0;
                        w_state_nx = S_REQ;
                    end else if (w_slot_free) begin
                        w_instr_nx   = i_imem_rdata;
                        w_out_pc_nx  = r_pending_pc;
                        w_out_pc4_nx = r_pending_pc + 32'd4;
                        w_valid_nx   = 1'b1;
                        w_state_nx   = S_REQ;
                    end else begin
                        w_skid_valid_nx = 1'b1;
                        w_skid_instr_nx = i_imem_rdata;
                        w_skid_pc_nx    = r_pending_pc;
                        w_state_nx      = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        if (r_skid_valid) begin
                            w_instr_nx   = r_skid_instr;
                            w_out_pc_nx  = r_skid_pc;
                            w_out_pc4_nx = r_skid_pc + 32'd4;
                            w_valid_nx   = 1'b1;
                        end else begin
                            w_valid_nx = 1'b0;
                        end
                        w_skid_valid_nx = 1'b0;
                        w_state_nx      = S_REQ;
                    end else begin
                        w_state_nx = S_HOLD;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end

        w_req_nx = (w_state_nx == S_REQ);
    end

    // State, PC, skid and IF/ID registers; reset clears outputs without a clock.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_pending_pc <= 32'd0;
            r_drop       <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= 32'd0;
            r_skid_pc    <= 32'd0;
            r_valid      <= 1'b0;
            r_instr      <= 32'd0;
            r_out_pc     <= 32'd0;
            r_out_pc4    <= 32'd0;
            r_req        <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_pc         <= w_pc_nx;
            r_pending_pc <= w_pending_pc_nx;
            r_drop       <= w_drop_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_skid_instr <= w_skid_instr_nx;
            r_skid_pc    <= w_skid_pc_nx;
            r_valid      <= w_valid_nx;
            r_instr      <= w_instr_nx;
            r_out_pc     <= w_out_pc_nx;
            r_out_pc4    <= w_out_pc4_nx;
            r_req        <= w_req_nx;
        end
    end

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_pc;
    assign o_instruction = r_instr;
    assign o_pc          = r_out_pc;
    assign o_pc_plus4    = r_out_pc4;
    assign o_valid       = r_valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: fetch, stall/skid, redirect,
// PC wrap (second instance) and asynchronous reset mid-fetch.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;

    logic        rst2_n;
    logic        req2;
    logic [31:0] addr2;
    logic        gnt2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic [31:0] pc4_2;
    logic        valid2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_stage u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_gnt(imem_gnt), .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
        .o_instruction(instr), .o_pc(pc), .o_pc_plus4(pc4), .o_valid(valid)
    );

    instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .i_clk(clk), .i_reset_n(rst2_n), .i_stall(1'b0), .i_redirect(1'b0),
        .i_redirect_pc(32'd0), .o_imem_req(req2), .o_imem_addr(addr2),
        .i_imem_gnt(gnt2), .i_imem_rvalid(rvalid2), .i_imem_rdata(rdata2),
        .o_instruction(instr2), .o_pc(pc2), .o_pc_plus4(pc4_2), .o_valid(valid2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [31:0] e_instr,
                             input logic [31:0] e_pc, input logic [31:0] e_pc4);
        check({tag, "_valid"}, {31'd0, valid}, 32'd1);
        check({tag, "_instr"}, instr, e_instr);
        check({tag, "_pc"}, pc, e_pc);
        check({tag, "_pc4"}, pc4, e_pc4);
    endtask

    // Check the pending request, grant it, then return the word one cycle later.
    task automatic fetch(input string tag, input logic [31:0] e_addr, input logic [31:0] data);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, e_addr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        rst2_n = 1'b0; gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = 32'd0;
        tick();
        tick();
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_pc4", pc4, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);

        // Test 1: back-to-back fetches, no stall.
        rst_n = 1'b1;
        tick();
        fetch("t1_f0", 32'h0040_0000, 32'h012A_4020);
        check_out("t1_w0", 32'h012A_4020, 32'h0040_0000, 32'h0040_0004);
        fetch("t1_f1", 32'h0040_0004, 32'h8D09_0004);
        check_out("t1_w1", 32'h8D09_0004, 32'h0040_0004, 32'h0040_0008);
        fetch("t1_f2", 32'h0040_0008, 32'h1109_0003);
        check_out("t1_w2", 32'h1109_0003, 32'h0040_0008, 32'h0040_000C);

        // Test 2: stall with a second word arriving lands it in the skid buffer.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        stall = 1'b1;
        fetch("t2_f0", 32'h0040_0000, 32'h012A_4020);
        check_out("t2_w0", 32'h012A_4020, 32'h0040_0000, 32'h0040_0004);
        fetch("t2_f1", 32'h0040_0004, 32'h8D09_0004);
        check("t2_hold_req", {31'd0, imem_req}, 32'd0);
        check_out("t2_hold", 32'h012A_4020, 32'h0040_0000, 32'h0040_0004);
        tick();
        check_out("t2_hold2", 32'h012A_4020, 32'h0040_0000, 32'h0040_0004);
        stall = 1'b0;
        tick();
        check_out("t2_skid", 32'h8D09_0004, 32'h0040_0004, 32'h0040_0008);
        fetch("t2_f2", 32'h0040_0008, 32'h1109_0003);
        check_out("t2_w2", 32'h1109_0003, 32'h0040_0008, 32'h0040_000C);

        // Test 3: redirect while waiting; the late response is dropped.
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0100;
        tick();
        redirect    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        check("t3_drop_valid", {31'd0, valid}, 32'd0);
        fetch("t3_f0", 32'h0040_0100, 32'h2002_0001);
        check_out("t3_w0", 32'h2002_0001, 32'h0040_0100, 32'h0040_0104);

        // Test 4: redirect beats stall; target low bits are forced to zero.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0103;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check("t4_valid", {31'd0, valid}, 32'd0);
        check("t4_req", {31'd0, imem_req}, 32'd1);
        check("t4_addr", imem_addr, 32'h0040_0100);

        // Test 6: asynchronous reset while in S_WAIT, then a stray rvalid in S_IDLE.
        fetch("t6_f0", 32'h0040_0100, 32'h8D09_0004);
        stall    = 1'b1;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("t6_pre_valid", {31'd0, valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, valid}, 32'd0);
        check("t6_async_instr", instr, 32'd0);
        check("t6_async_pc", pc, 32'd0);
        check("t6_async_pc4", pc4, 32'd0);
        check("t6_async_req", {31'd0, imem_req}, 32'd0);
        tick();
        rst_n       = 1'b1;
        stall       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        check("t6_ign_valid", {31'd0, valid}, 32'd0);
        check("t6_ign_instr", instr, 32'd0);
        tick();
        fetch("t6_f1", 32'h0040_0000, 32'h012A_4020);
        check_out("t6_w1", 32'h012A_4020, 32'h0040_0000, 32'h0040_0004);

        // Test 5: PC wrap from 32'hFFFF_FFFC on the second instance.
        rst2_n = 1'b1;
        tick();
        check("t5_req", {31'd0, req2}, 32'd1);
        check("t5_addr", addr2, 32'hFFFF_FFFC);
        gnt2 = 1'b1;
        tick();
        gnt2    = 1'b0;
        rvalid2 = 1'b1;
        rdata2  = 32'h012A_4020;
        tick();
        rvalid2 = 1'b0;
        check("t5_valid", {31'd0, valid2}, 32'd1);
        check("t5_instr", instr2, 32'h012A_4020);
        check("t5_pc", pc2, 32'hFFFF_FFFC);
        check("t5_pc4", pc4_2, 32'h0000_0000);
        check("t5_req2", {31'd0, req2}, 32'd1);
        check("t5_addr2", addr2, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
IF stage of the five-stage MIPS pipeline. It is the producer side of the 32-bit instruction word that the ID-stage decoder consumes. It holds the PC and issues one word fetch at a time over a request/grant/response instruction-memory interface. It presents the fetched word with its PC in an IF/ID output register, honouring stall from the hazard unit and redirect from branch/jump resolution.

Parameters:
RESET_PC  32'h0040_0000  PC loaded on reset; bits [1:0] must be 0.

Ports:
i_clk  input  1  clock, all state on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_stall  input  1  ID stage cannot accept; output register must hold
i_redirect  input  1  one-cycle pulse: branch/jump taken, flush and refetch
i_redirect_pc  input  32  redirect target; bits [1:0] ignored, forced to 0
o_imem_req  output  1  fetch request valid
o_imem_addr  output  32  fetch word address
i_imem_gnt  input  1  memory accepts request this cycle (req & gnt = accepted)
i_imem_rvalid  input  1  response word valid
i_imem_rdata  input  32  response instruction word
o_instruction  output  32  instruction to ID stage
o_pc  output  32  address of o_instruction
o_pc_plus4  output  32  o_pc + 4, mod 2^32
o_valid  output  1  o_instruction/o_pc valid

Behaviour:
- Reset (async, i_reset_n=0): pc=RESET_PC, state=S_IDLE, o_valid=0, o_instruction=0 (NOP), o_pc=0, o_pc_plus4=0, o_imem_req=0, drop flag=0, skid buffer empty.
- Consume event: o_valid & ~i_stall at a rising edge. Output slot free = ~o_valid | ~i_stall.
- States:
  - S_IDLE: req=0. Next cycle goes to S_REQ.
  - S_REQ: req=1, addr=pc. On gnt: pending_pc<=pc, pc<=pc+4, go to S_WAIT. Addr stays stable until granted, except on redirect.
  - S_WAIT: req=0, waits for rvalid. On rvalid with drop=1: discard, drop<=0, go to S_REQ. On rvalid with slot free: o_instruction<=rdata, o_pc<=pending_pc, o_pc_plus4<=pending_pc+4, o_valid<=1, go to S_REQ. On rvalid with slot not free: capture into skid buffer, go to S_HOLD.
  - S_HOLD: req=0. When ~i_stall: move skid into output register (o_valid=1), go to S_REQ.
- o_valid clears after a consume unless a new word loads on the same edge.
- Output registers are stable while o_valid & i_stall.
- At most one outstanding request. Peak throughput is one instruction per 2 cycles with 1-cycle memory latency.
- Redirect has highest priority over stall and response, in every state:
  - pc<={i_redirect_pc[31:2],2'b00}; o_valid<=0; skid cleared.
  - S_WAIT with no rvalid: stay in S_WAIT, drop<=1.
  - S_WAIT with rvalid on the same edge: discard, go to S_REQ.
  - S_REQ with gnt on the same edge: go to S_WAIT with drop<=1; pc is the redirect target, not +4.
  - S_REQ without gnt: stay in S_REQ; o_imem_addr shows the target next cycle.
  - S_HOLD / S_IDLE: go to S_REQ.
- Redirect and stall together: redirect wins, o_valid=0 next cycle.
- PC arithmetic: 32-bit modular. 32'hFFFF_FFFC+4 = 0, and o_pc_plus4 wraps the same way.
- rvalid outside S_WAIT is ignored. This covers late responses after a mid-operation reset.
- Reset asserted mid-fetch: outputs clear immediately, without waiting for a clock. After release, fetch restarts from RESET_PC via S_IDLE.

Test Plan:
1. Reset release, memory gnt same cycle, rvalid next cycle, words 0x012A4020, 0x8D090004, 0x11090003 -> requests issue at 0x00400000/04/08. o_valid shows those words with o_pc 0x00400000/04/08 and o_pc_plus4 0x00400004/08/0C.
2. Hold i_stall=1 while o_valid shows 0x012A4020; next response 0x8D090004 arrives -> S_HOLD, o_imem_req=0, output unchanged. Release stall -> output becomes 0x8D090004/pc 0x00400004 next edge. Fetch resumes at 0x00400008, with no loss or duplicate.
3. i_redirect with i_redirect_pc=0x00400100 while in S_WAIT -> late rvalid word is discarded. Next request is at 0x00400100 and next o_valid has o_pc=0x00400100.
4. i_redirect_pc=0x00400103, coincident with i_stall=1 and o_valid=1 -> o_valid=0 next cycle, next request address 0x00400100.
5. RESET_PC=32'hFFFF_FFFC -> first o_pc_plus4=0x00000000; second request address 0x00000000.
6. Drive i_reset_n low in S_WAIT, then assert rvalid after release while in S_IDLE -> outputs are 0 asynchronously and rvalid is ignored. First request after release is at RESET_PC.
